uart_tx_mmio: RTL and testbench



---
 rtl/uart_tx_mmio_if.sv | 11 +
 rtl/uart_tx_mmio.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_mmio_if.sv
// CPU store/load bus into the UART window: address, write data/strobe, read data and window select.
interface uart_tx_mmio_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr_en;
  logic [31:0] rdata;
  logic        sel;

  modport master (output addr, wdata, wr_en, input rdata, sel);
  modport slave  (input addr, wdata, wr_en, output rdata, sel);
endinterface

// File: rtl/uart_tx_mmio.sv
// MMIO 8N1 UART transmitter with FIFO; DATA write at edge N drives start bit at N+1.
// No backpressure: writes to a full FIFO are dropped and set sticky overflow. UART_PARITY_EN adds an even parity bit.
module uart_tx_mmio #(
  parameter int          CLK_HZ     = 50000000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_mmio_if.slave bus,
  output logic          tx,
  output logic          busy
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic          full, empty;
  logic          sel, wr_data_reg, push, pop, ovf_set, ovf_clr;

  state_t        state, state_nxt;
  logic [CW-1:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_nxt, bit_end, tx_active;
  logic [7:0]    head;
`ifdef UART_PARITY_EN
  logic          par, par_nxt;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.wdata[31:8], bus.addr[1:0]};

  assign sel         = (bus.addr[31:3] == BASE_ADDR[31:3]);
  assign bus.sel     = sel;
  assign full        = (count == (AW+1)'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign wr_data_reg = sel & bus.wr_en & ~bus.addr[2];
  assign push        = wr_data_reg & ~full;
  assign ovf_set     = wr_data_reg & full;
  assign ovf_clr     = sel & bus.wr_en & bus.addr[2] & bus.wdata[3];
  assign head        = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
`ifdef UART_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
      tx       <= tx_nxt;
`ifdef UART_PARITY_EN
      par      <= par_nxt;
`endif
    end
  end

  assign bit_end = (baud_cnt == CW'(DIV - 1));

  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = bit_end ? '0 : baud_cnt + CW'(1);
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift;
    pop          = 1'b0;
`ifdef UART_PARITY_EN
    par_nxt      = par;
`endif
    case (state)
      IDLE: begin
        baud_cnt_nxt = '0;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = head;
          state_nxt = START;
`ifdef UART_PARITY_EN
          par_nxt   = ^head;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt   = {1'b0, shift[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (bit_end) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit so queued bytes leave no idle gap.
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = head;
            state_nxt = START;
`ifdef UART_PARITY_EN
            par_nxt   = ^head;
`endif
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
`ifdef UART_PARITY_EN
      PARITY:  tx_nxt = par_nxt;
`endif
      default: tx_nxt = 1'b1;
    endcase
  end

  assign tx_active = (state != IDLE);
  assign busy      = tx_active | ~empty;

  always_comb begin
    bus.rdata = '0;
    if (sel && bus.addr[2])
      bus.rdata = {16'b0, 8'(count), 4'b0, overflow, tx_active, empty, full};
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio at DIV=10: directed writes feed an expected-byte queue checked by a line monitor.
module tb_uart_tx_mmio;
  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int DIV = 10;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FR = NB * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx, busy;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  uart_tx_mmio_if b ();

  uart_tx_mmio #(
    .CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(8), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst), .bus(b), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int         start_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: detects start bits, samples mid-bit and scores frames against exp_q.
  bit         mon_on = 1'b0;
  int         mon_start, off, k;
  logic [7:0] mon_byte, e;
  logic       mon_par;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      mon_on = 1'b0;
      exp_q.delete();
    end else if (!mon_on) begin
      if (tx === 1'b0) begin
        mon_on    = 1'b1;
        mon_start = cyc;
        start_q.push_back(cyc);
      end
    end else begin
      off = cyc - mon_start;
      if (off >= DIV/2 && ((off - DIV/2) % DIV) == 0) begin
        k = (off - DIV/2) / DIV;
        if (k == 0) check("start_bit", {31'b0, tx}, 32'd0);
        else if (k <= 8) mon_byte[k-1] = tx;
`ifdef UART_PARITY_EN
        else if (k == 9) mon_par = tx;
`endif
        else begin
          check("stop_bit", {31'b0, tx}, 32'd1);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_frame: got 0x%02h expected no frame", mon_byte);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", {24'b0, mon_byte}, {24'b0, e});
`ifdef UART_PARITY_EN
            check("parity", {31'b0, mon_par}, {31'b0, ^e});
`endif
          end
          mon_on = 1'b0;
        end
      end
    end
  end

  int last_wr;

  // Called aligned to a falling edge; returns on the next falling edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    b.addr  = a;
    b.wdata = d;
    b.wr_en = 1'b1;
    @(negedge clk);
    last_wr = cyc;
    b.wr_en = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    bus_write(BASE, {24'b0, d});
    exp_q.push_back(d);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic s);
    b.addr  = a;
    b.wr_en = 1'b0;
    #1;
    d = b.rdata;
    s = b.sel;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i;
    i = 0;
    while ((busy || mon_on || exp_q.size() != 0) && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (i >= budget) begin
      tests++;
      fails++;
      $display("FAIL timeout_%s: got busy=%0d still waiting, expected idle within %0d cycles", name, busy, budget);
    end
  endtask

  logic [31:0] rv;
  logic        sv;
  int          n, n0, i;

  initial begin
    b.addr  = '0;
    b.wdata = '0;
    b.wr_en = 1'b0;
    rst     = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Activity then reset held 2 cycles.
    send(8'h3C);
    send(8'hC5);
    repeat (23) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rd(BASE + 32'd4, rv, sv);
    check("rst_status", rv, 32'h0000_0002);
    rst = 1'b0;
    @(negedge clk);

    // Single byte 0x55: latency, content, busy fall.
    start_q.delete();
    send(8'h55);
    n = last_wr;
    check("pre_start_tx", {31'b0, tx}, 32'd1);
    @(negedge clk);
    check("start_latency_tx", {31'b0, tx}, 32'd0);
    i = 0;
    while (busy && i < 300) begin
      @(negedge clk);
      i++;
    end
    check("busy_fall_cycle", cyc, n + 1 + FR);
    check("single_start_cycle", start_q.size() > 0 ? start_q[0] : -1, n + 1);
    wait_idle(50, "single");

    // Back-to-back frames.
    start_q.delete();
    send(8'hA3);
    send(8'h0F);
    wait_idle(400, "b2b");
    check("b2b_frames", start_q.size(), 2);
    if (start_q.size() >= 2)
      check("b2b_gap", start_q[1] - start_q[0], FR);

    // Overflow.
    for (int j = 0; j < 9; j++) send(8'h10 + 8'(j));
    rd(BASE + 32'd4, rv, sv);
    check("ovf_full_status", rv, 32'h0000_0805);
    bus_write(BASE, 32'h0000_00EE);
    rd(BASE + 32'd4, rv, sv);
    check("ovf_set_status", rv, 32'h0000_080D);
    bus_write(BASE + 32'd4, 32'h0000_0008);
    rd(BASE + 32'd4, rv, sv);
    check("ovf_clr_status", rv, 32'h0000_0805);
    wait_idle(1500, "ovf_drain");

    // Address decode.
    start_q.delete();
    rd(BASE + 32'd8, rv, sv);
    check("out_win_sel", {31'b0, sv}, 32'd0);
    check("out_win_rdata", rv, 32'd0);
    bus_write(BASE + 32'd8, 32'h0000_005A);
    rd(BASE + 32'd7, rv, sv);
    check("status_alias_sel", {31'b0, sv}, 32'd1);
    check("status_alias", rv, 32'h0000_0002);
    rd(BASE, rv, sv);
    check("data_read_zero", rv, 32'd0);
    repeat (30) @(negedge clk);
    check("out_win_no_frame", start_q.size(), 0);
    check("out_win_busy", {31'b0, busy}, 32'd0);

    // Reset during data bit 3 with three bytes queued.
    start_q.delete();
    send(8'hF0);
    n0 = last_wr;
    send(8'h81);
    send(8'h42);
    send(8'h99);
    while (cyc < n0 + 45) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", {31'b0, tx}, 32'd1);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    rd(BASE + 32'd4, rv, sv);
    check("midrst_status", rv, 32'h0000_0002);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check("midrst_no_more_frames", start_q.size(), 1);

`ifdef UART_PARITY_EN
    send(8'h07);
    n = last_wr;
    i = 0;
    while (busy && i < 300) begin
      @(negedge clk);
      i++;
    end
    check("parity_frame_len", cyc, n + 1 + 110);
`endif

    wait_idle(2000, "final");
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
